// File: rtl/firing_sequencer_pkg.sv
// Shared definitions for the firing sequencer and the shot datapath:
// control codes, FSM state encoding and the registered output bundle.
package firing_pkg;

  localparam logic [2:0] CTRL_RELOAD = 3'b000;
  localparam logic [2:0] CTRL_HOLD   = 3'b001;
  localparam logic [2:0] CTRL_SHOT   = 3'b011;

  typedef enum logic [1:0] {
    RELOAD  = 2'd0,
    SHOT    = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  typedef struct packed {
    logic [2:0] control;
    logic       flash;
    logic       busy;
  } out_t;

  // Output decode used when loading the output register alongside the state.
  function automatic out_t outs_of(input state_t s);
    out_t o;
    o.control = CTRL_RELOAD;
    o.flash   = 1'b0;
    o.busy    = (s != RELOAD);
    case (s)
      SHOT:    o.control = CTRL_SHOT;
      HOLD: begin
        o.control = CTRL_HOLD;
        o.flash   = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/firing_sequencer_if.sv
// Trigger/datapath signal bundle between the sequencer (slave) and its
// environment (master).
interface firing_sequencer_if;
  logic       trigger;
  logic       enable;
  logic       leave;
  logic [1:0] remaining_shots;
  logic       is_shot;
  logic       escape;
  logic [2:0] control;
  logic       flash;
  logic       busy;

  modport master (
    output trigger, enable, leave, remaining_shots, is_shot, escape,
    input  control, flash, busy
  );

  modport slave (
    input  trigger, enable, leave, remaining_shots, is_shot, escape,
    output control, flash, busy
  );
endinterface

// File: rtl/firing_sequencer_trigger_debounce.sv
// Raw trigger conditioning: 2-flop synchroniser, stability debouncer and a
// rising-edge detector on the debounced level.
module trigger_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 22
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_trigger,
  output logic o_level,
  output logic o_trig_pulse
);

  localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_d;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_trigger;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      // Any agreement with the current level restarts the stability window.
      if (r_sync2 != r_level) begin
        if (r_cnt == DEB_TC) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level      = r_level;
  assign o_trig_pulse = r_level & ~r_level_d;

endmodule

// File: rtl/firing_sequencer.sv
// Shot sequencer: turns debounced trigger presses into one SHOT cycle,
// a HOLD flash window, and a wait for trigger release.
//
// state   | meaning
// RELOAD  | idle, control=000, waiting for an accepted press
// SHOT    | control=011 for a single cycle
// HOLD    | control=001, flash on, FLASH_CYCLES long
// RELEASE | control=000, waits for debounced trigger low (no auto-fire)
module firing_sequencer
  import firing_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FLASH_CYCLES    = 2500000,
  parameter int CNT_W           = 22
) (
  input logic               clk,
  input logic               reset_n,
  firing_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] FLASH_TC = CNT_W'(FLASH_CYCLES - 1);

  logic             w_level;
  logic             w_trig_pulse;
  logic             w_fire_ok;
  state_t           r_state;
  logic [CNT_W-1:0] r_flash_cnt;
  out_t             r_out;

  trigger_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_trigger    (bus.trigger),
    .o_level      (w_level),
    .o_trig_pulse (w_trig_pulse)
  );

  assign w_fire_ok = w_trig_pulse & bus.enable & (bus.remaining_shots != 2'd0)
                   & ~bus.is_shot & ~bus.escape;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= RELOAD;
      r_flash_cnt <= '0;
      r_out       <= outs_of(RELOAD);
    end else if (bus.leave) begin
      // Abort wins over any press seen in the same cycle.
      r_state     <= RELOAD;
      r_flash_cnt <= '0;
      r_out       <= outs_of(RELOAD);
    end else begin
      case (r_state)
        RELOAD: begin
          if (w_fire_ok) begin
            r_state     <= SHOT;
            r_flash_cnt <= '0;
            r_out       <= outs_of(SHOT);
          end
        end
        SHOT: begin
          r_state     <= HOLD;
          r_flash_cnt <= '0;
          r_out       <= outs_of(HOLD);
        end
        HOLD: begin
          if (r_flash_cnt == FLASH_TC) begin
            r_state <= RELEASE;
            r_out   <= outs_of(RELEASE);
          end else begin
            r_flash_cnt <= r_flash_cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (!w_level) begin
            r_state <= RELOAD;
            r_out   <= outs_of(RELOAD);
          end
        end
        default: begin
          r_state     <= RELOAD;
          r_flash_cnt <= '0;
          r_out       <= outs_of(RELOAD);
        end
      endcase
    end
  end

  assign bus.control = r_out.control;
  assign bus.flash   = r_out.flash;
  assign bus.busy    = r_out.busy;

endmodule
